// File: rtl/seq_alu_pkg.sv
// Shared opcode, FSM state and iteration-count definitions for the sequential ALU.
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_PASSB  = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One quotient/product bit per cycle, so the iteration count equals the width.
  function automatic int muldiv_cycles(input int xlen);
    return xlen;
  endfunction

  localparam int MULDIV_CYCLES = muldiv_cycles(32);

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider on sign-magnitude operands.
// done is high during the final iteration; result is valid from the next cycle until the next start.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int NCYC = muldiv_cycles(XLEN);

  logic              busy_q;
  logic [SHW-1:0]    cnt_q;
  logic [4:0]        op_q;
  logic              nq_q, nr_q;
  logic [XLEN:0]     hi_q;
  logic [XLEN-1:0]   lo_q, m_q;

  logic              a_sgn, b_sgn, is_div;
  logic [XLEN-1:0]   a_mag, b_mag, quo_s, rem_s;
  logic [XLEN:0]     mul_sum, div_sh, div_tr;
  logic [2*XLEN-1:0] prod, prod_s;

  assign a_sgn = a[XLEN-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign b_sgn = b[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign a_mag = a_sgn ? -a : a;
  assign b_mag = b_sgn ? -b : b;
  assign is_div = (op_q >= OP_DIV) && (op_q <= OP_REMU);

  assign mul_sum = lo_q[0] ? (hi_q + {1'b0, m_q}) : hi_q;
  assign div_sh  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
  assign div_tr  = div_sh - {1'b0, m_q};

  assign done = busy_q && (cnt_q == SHW'(NCYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      op_q   <= op;
      // A zero divisor leaves the quotient all-ones; it must not be negated.
      nq_q   <= (a_sgn ^ b_sgn) && (b != '0);
      nr_q   <= a_sgn;
      hi_q   <= '0;
      lo_q   <= a_mag;
      m_q    <= b_mag;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
      if (is_div) begin
        hi_q <= div_tr[XLEN] ? div_sh : div_tr;
        lo_q <= {lo_q[XLEN-2:0], ~div_tr[XLEN]};
      end else begin
        hi_q <= {1'b0, mul_sum[XLEN:1]};
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign prod   = {hi_q[XLEN-1:0], lo_q};
  assign prod_s = nq_q ? -prod : prod;
  assign quo_s  = nq_q ? -lo_q : lo_q;
  assign rem_s  = nr_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:                      result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result = quo_s;
      OP_REM, OP_REMU:             result = rem_s;
      default:                     result = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops answer one cycle after acceptance, mul/div after XLEN+1.
// One request in flight; in_ready only in IDLE, result held in DONE until out_ready.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cmp_eq,
  output logic            cmp_lt,
  output logic            cmp_ltu,
  output logic            busy
);

  state_e          state_q, state_d;
  alu_op_e         op;
  logic            accept, md_start, md_done, md_sel_q;
  logic            eq, lt, ltu, eq_q, lt_q, ltu_q;
  logic [XLEN-1:0] sc_res, res_q, md_res;
  logic [SHW-1:0]  shamt;

  assign op    = alu_op_e'(alu_op);
  assign shamt = op_b[SHW-1:0];
  assign eq    = (op_a == op_b);
  assign lt    = ($signed(op_a) < $signed(op_b));
  assign ltu   = (op_a < op_b);

  always_comb begin
    sc_res = '0;
    case (op)
      OP_ADD:   sc_res = op_a + op_b;
      OP_SUB:   sc_res = op_a - op_b;
      OP_AND:   sc_res = op_a & op_b;
      OP_OR:    sc_res = op_a | op_b;
      OP_XOR:   sc_res = op_a ^ op_b;
      OP_SLL:   sc_res = op_a << shamt;
      OP_SRL:   sc_res = op_a >> shamt;
      OP_SRA:   sc_res = $signed(op_a) >>> shamt;
      OP_SLT:   sc_res = XLEN'(lt);
      OP_SLTU:  sc_res = XLEN'(ltu);
      OP_PASSB: sc_res = op_b;
      default:  sc_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    md_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (is_muldiv(alu_op)) begin
            md_start = 1'b1;
            state_d  = S_CALC;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_CALC:  if (md_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q    <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      md_sel_q <= 1'b0;
    end else if (accept) begin
      res_q    <= sc_res;
      eq_q     <= eq;
      lt_q     <= lt;
      ltu_q    <= ltu;
      md_sel_q <= is_muldiv(alu_op);
    end
  end

  seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (alu_op),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_res)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign result    = md_sel_q ? md_res : res_q;
  assign cmp_eq    = eq_q;
  assign cmp_lt    = lt_q;
  assign cmp_ltu   = ltu_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized traffic against an arithmetic model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int XLEN = 32;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        cmp_eq, cmp_lt, cmp_ltu, busy;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  alu_op;
  logic        man_rdy, rnd_rdy, rdy_rand;

  typedef struct {
    logic [31:0] res;
    logic        eq;
    logic        lt;
    logic        ltu;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  assign out_ready = rdy_rand ? rnd_rdy : man_rdy;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .cmp_ltu(cmp_ltu), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa, sb;
    sa    = $signed(a);
    sb    = $signed(b);
    p     = '0;
    e.res = '0;
    e.eq  = (a == b);
    e.lt  = (sa < sb);
    e.ltu = (a < b);
    e.lat = 1;
    e.acc = 0;
    case (op)
      OP_ADD:    e.res = a + b;
      OP_SUB:    e.res = a - b;
      OP_AND:    e.res = a & b;
      OP_OR:     e.res = a | b;
      OP_XOR:    e.res = a ^ b;
      OP_SLL:    e.res = a << b[4:0];
      OP_SRL:    e.res = a >> b[4:0];
      OP_SRA:    e.res = 32'(sa >>> b[4:0]);
      OP_SLT:    e.res = {31'b0, e.lt};
      OP_SLTU:   e.res = {31'b0, e.ltu};
      OP_PASSB:  e.res = b;
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; end
      OP_MULH:   begin p = 64'(longint'(sa) * longint'(sb)); e.res = p[63:32]; end
      OP_MULHSU: begin p = 64'(longint'(sa) * longint'({32'b0, b})); e.res = p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; end
      OP_DIV: begin
        if (b == 0) e.res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
        else e.res = 32'(sa / sb);
      end
      OP_REM: begin
        if (b == 0) e.res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = '0;
        else e.res = 32'(sa % sb);
      end
      OP_DIVU:   e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   e.res = (b == 0) ? a : a % b;
      default:   e.res = '0;
    endcase
    if (op >= OP_MUL && op <= OP_REMU) e.lat = XLEN + 1;
    return e;
  endfunction

  // Scoreboard monitor: pops one expectation per output transaction and checks it stays put.
  initial begin
    exp_t cur;
    bit   in_txn;
    in_txn = 0;
    cur    = model(5'd0, 32'd0, 32'd0);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 0;
      end else if (out_valid) begin
        if (!in_txn) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'(result), 64'hDEAD_0000_0000_0000);
            cur.res = result;
          end else begin
            cur = q.pop_front();
            chk("result", 64'(result), 64'(cur.res));
            chk("cmp_eq", 64'(cmp_eq), 64'(cur.eq));
            chk("cmp_lt", 64'(cmp_lt), 64'(cur.lt));
            chk("cmp_ltu", 64'(cmp_ltu), 64'(cur.ltu));
            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
          in_txn = 1;
        end else begin
          chk("hold_result", 64'(result), 64'(cur.res));
        end
        if (out_ready) in_txn = 0;
      end
    end
  end

  task automatic issue_k(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] k, input bit use_k);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(op, a, b);
    if (use_k) e.res = k;
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_op   = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0 || out_valid) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    alu_op   = '0;
    man_rdy  = 1'b1;
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({cmp_eq, cmp_lt, cmp_ltu}), 64'd0);

    // Directed corner cases.
    issue_k(OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    issue_k(OP_SRA,   32'h8000_0000, 32'h24,        32'hF800_0000, 1);
    issue_k(OP_SRL,   32'h8000_0000, 32'h24,        32'h0800_0000, 1);
    issue_k(OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    issue_k(OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    issue_k(OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1);
    issue_k(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    issue_k(OP_DIV,   32'd7,         32'd0,         32'hFFFF_FFFF, 1);
    issue_k(OP_REMU,  32'd7,         32'd0,         32'd7,         1);
    issue_k(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue_k(OP_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1);
    issue_k(5'd25,    32'd123,       32'd456,       32'd0,         1);
    drain();

    // Output backpressure: result held, new requests ignored, in_ready back after release.
    man_rdy = 1'b0;
    issue_k(OP_ADD, 32'd10, 32'd20, 32'd30, 1);
    @(negedge clk);
    chk("hold_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      alu_op   = OP_SUB;
      op_a     = $urandom;
      op_b     = $urandom;
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    man_rdy  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    drain();

    // Reset in the middle of a divide discards it.
    issue_k(OP_DIVU, 32'd5, 32'd7, 32'd0, 1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("calc_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_flags", 64'({cmp_eq, cmp_lt, cmp_ltu}), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("no_ghost_output", 64'(seen), 64'd0);
    issue_k(OP_ADD, 32'd2, 32'd3, 32'd5, 1);
    drain();

    // Randomized traffic with random output backpressure.
    rdy_rand = 1'b1;
    repeat (150) issue_k(5'($urandom_range(0, 22)), pick(), pick(), 32'd0, 0);
    drain();
    rdy_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
